chaos_lfsr_keystream: RTL and testbench
=======================================

# chaos_lfsr_keystream

Downstream consumer of the Q1.15 chaotic map generator. It collects low-order bits from successive chaotic samples into a seed word and loads that seed into a Galois LFSR. It then streams LFSR words out over a valid/ready handshake, and re-collects a fresh chaotic seed every RESEED_PERIOD output words. This is the chaotic-LFSR keystream stage of the design.

## Interface
- LFSR_W, 16: LFSR and output word width.
- BITS_PER_SAMPLE, 2: LSBs taken from each chaotic sample; must divide LFSR_W, range 1..16.
- RESEED_PERIOD, 256: words emitted per seed; must be ≥1.
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  start / continue request.
- chaos_in  in  16  signed Q1.15 sample from the chaotic map.
- chaos_valid  in  1  sample valid; tie high for a free-running generator.
- chaos_ready  out  1  sample accepted on chaos_valid & chaos_ready.
- ks_data  out  LFSR_W  keystream word.
- ks_valid  out  1  keystream word valid.
- ks_ready  in  1  downstream accepts the word.
- reseed_count  out  8  number of completed seed loads; wraps 255→0.

## Operation
- States are IDLE, COLLECT and RUN.
- **Reset values:** state=IDLE, lfsr=1, seed_sr=0, sample_cnt=0, word_cnt=0, reseed_count=0, chaos_ready=0, ks_valid=0, ks_data=1.
- **IDLE:**
  - If enable=1, go to COLLECT.
  - Otherwise hold.
- **COLLECT:**
  - chaos_ready=1 and ks_valid=0.
  - Each accepted sample: seed_sr ← {seed_sr[LFSR_W-1-B:0], chaos_in[B-1:0]}, where B=BITS_PER_SAMPLE; sample_cnt increments.
  - On the accept that completes LFSR_W/B samples:
    - lfsr ← seed_next, or 1 if seed_next==0 (zero-lock guard).
    - reseed_count increments; sample_cnt and word_cnt clear.
    - Next state is RUN.
  - If enable=0 while in COLLECT: go to IDLE and clear sample_cnt and seed_sr. The partial seed is discarded.
- **RUN:**
  - ks_valid=1, ks_data=lfsr, chaos_ready=0.
  - On handshake (ks_valid & ks_ready):
    - lfsr ← step(lfsr), where step(v) = (v>>1) ^ (v[0] ? TAPS : 0).
    - word_cnt increments.
    - If the word just accepted is number RESEED_PERIOD, go to COLLECT.
    - Else if enable=0, go to IDLE.
    - Else stay in RUN.
  - Without a handshake, ks_data and ks_valid hold stable; enable is ignored until the handshake.
- Seed selection ignores the sign and integer bits of chaos_in; only chaos_in[B-1:0] is used.
- All counters are unsigned.
  - sample_cnt width is clog2(LFSR_W/B + 1).
  - word_cnt width is clog2(RESEED_PERIOD + 1).

## Timing
- Once a collect starts, a seed needs LFSR_W/B accepted samples: 8 cycles at the defaults with chaos_valid high.
- The first ks_valid appears in the cycle after the final sample accept, with ks_data equal to the seed.
- In RUN, throughput is 1 word/cycle while ks_ready is held high.
- The reseed gap is LFSR_W/B cycles with ks_valid low.
- Simultaneous events:
  - A handshake on the RESEED_PERIOD-th word takes priority over enable=0; the block goes to COLLECT, not IDLE.
  - Reset overrides everything; reset values are visible in the cycle after reset is sampled, including mid-RUN and mid-COLLECT.
- Registered outputs only; there is no combinational path from input to output.

## Structure
- Shared package chaos_pkg holds:
  - typedef q1_15_t (signed [15:0]);
  - state enum {IDLE, COLLECT, RUN};
  - constant DEFAULT_TAPS_16 = 16'hB400;
  - function lfsr_galois_step.
- Sub-module chaos_seed_collector is natural. It owns seed_sr and sample_cnt, takes a sample-accept input and a clear input, and outputs seed_done and seed. The top-level FSM and the LFSR stay in chaos_lfsr_keystream.

## Test plan
- **Reset:** assert reset for 2 cycles. Expect ks_valid=0, chaos_ready=0, ks_data=0x0001, reseed_count=0.
- **Seed and step:** enable=1, ks_ready=1, feed samples whose low 2 bits are 1,2,3,0,1,2,3,0.
  - Expect seed 0x6C6C.
  - Expect ks_data sequence 0x6C6C, 0x3636, 0x1B1B, 0xB98D.
  - Expect reseed_count=1.
- **Zero seed:** all sample LSBs 0. Expect ks_data sequence 0x0001, 0xB400.
- **Backpressure:** drop ks_ready for 5 cycles in RUN. Expect ks_data and ks_valid held, then the sequence resumes with no skipped word.
- **Reseed:** with RESEED_PERIOD=4, after the 4th handshake expect:
  - ks_valid=0 and chaos_ready=1 in the next cycle;
  - the new seed's first word 8 cycles later;
  - reseed_count=2.
- **Abort and reset:**
  - Drop enable after 3 samples in COLLECT. Expect IDLE; re-enable requires 8 fresh samples.
  - Assert reset mid-RUN. Expect reset values in the next cycle.

Source files
------------

// File: rtl/chaos_pkg.sv
// Shared types and helpers for the chaotic-map keystream path.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: n/a.
package chaos_pkg;

  // Signed Q1.15 sample as produced by the chaotic map generator
  typedef logic signed [15:0] q1_15_t;

  // Keystream controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RUN     = 2'd2
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;

  // Widest LFSR the step helper supports
  localparam int LFSR_MAX_W = 32;

  // One right-shifting Galois step. Callers zero-extend narrower
  // registers/masks to 32 bits and keep the low bits of the result; the
  // upper bits stay zero as long as the mask fits the register width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_galois_step(
    input logic [LFSR_MAX_W-1:0] v,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic [LFSR_MAX_W-1:0] r;
    r = v >> 1;
    if (v[0]) begin
      r = r ^ taps;
    end
    return r;
  endfunction

endpackage

// File: rtl/chaos_seed_collector.sv
// Shifts the low B bits of each accepted chaotic sample into a W-bit seed word.
// Latency: seed/seed_done are combinational on the completing accept (W/B accepts per seed).
// Backpressure: none of its own; the caller decides when a sample is accepted.
module chaos_seed_collector
  import chaos_pkg::*;
#(
  parameter int W = 16,
  parameter int B = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         accept,
  input  logic         clear,
  input  logic [B-1:0] sample_bits,
  output logic         seed_done,
  output logic [W-1:0] seed
);

  localparam int N  = W / B;
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]  seed_sr;
  logic [CW-1:0] sample_cnt;
  logic [W-1:0]  seed_next;
  logic          last_sample;

  // New samples enter at the bottom so the first sample ends up in the MSBs
  generate
    if (B == W) begin : g_full_word
      assign seed_next = sample_bits;
    end else begin : g_shift
      assign seed_next = {seed_sr[W-1-B:0], sample_bits};
    end
  endgenerate

  assign last_sample = (sample_cnt == CW'(N - 1));
  assign seed_done   = accept && last_sample;
  // Exposed as the next value so the caller can load it on the completing accept
  assign seed        = seed_next;

  // Shift register and sample counter; clear discards a partial seed
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      seed_sr    <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      seed_sr <= seed_next;
      if (last_sample) begin
        sample_cnt <= '0;
      end else begin
        sample_cnt <= sample_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chaos_lfsr_keystream.sv
// Seeds a Galois LFSR from chaotic-sample LSBs and streams its words, reseeding every RESEED_PERIOD words.
// Latency: first word one cycle after the final seed sample; then 1 word/cycle; reseed gap LFSR_W/B cycles.
// Backpressure: ks_data/ks_valid hold while ks_ready is low; chaos_ready is high only while collecting.
module chaos_lfsr_keystream
  import chaos_pkg::*;
#(
  parameter int                 LFSR_W          = 16,
  parameter int                 BITS_PER_SAMPLE = 2,
  parameter int                 RESEED_PERIOD   = 256,
  parameter logic [LFSR_W-1:0]  TAPS            = DEFAULT_TAPS_16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  q1_15_t            chaos_in,
  input  logic              chaos_valid,
  output logic              chaos_ready,
  output logic [LFSR_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [7:0]        reseed_count
);

  localparam int B   = BITS_PER_SAMPLE;
  localparam int WCW = $clog2(RESEED_PERIOD + 1);

  // Elaboration-time sanity checks on the parameter set
  generate
    if (B < 1 || B > 16) begin : g_bad_bits
      $error("BITS_PER_SAMPLE must be in 1..16");
    end
    if ((LFSR_W % B) != 0) begin : g_bad_div
      $error("BITS_PER_SAMPLE must divide LFSR_W");
    end
    if (LFSR_W > LFSR_MAX_W || LFSR_W < B) begin : g_bad_width
      $error("LFSR_W out of supported range");
    end
    if (RESEED_PERIOD < 1) begin : g_bad_period
      $error("RESEED_PERIOD must be at least 1");
    end
  endgenerate

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_step;
  logic [WCW-1:0]    word_cnt;

  logic              sample_accept;
  logic              collect_abort;
  logic              seed_done;
  logic [LFSR_W-1:0] seed;
  logic              ks_hs;
  logic              last_word;

  // Only the fractional LSBs feed the seed; sign/integer bits are deliberately dropped
  logic              unused_chaos_bits;
  assign unused_chaos_bits = ^chaos_in;

  // An enable drop in COLLECT wins over a same-cycle sample: the partial seed is thrown away
  assign collect_abort = (state == COLLECT) && !enable;
  assign sample_accept = (state == COLLECT) && enable && chaos_valid && chaos_ready;

  assign ks_hs     = ks_valid && ks_ready;
  assign last_word = (word_cnt == WCW'(RESEED_PERIOD - 1));
  assign lfsr_step = LFSR_W'(lfsr_galois_step(32'(lfsr), 32'(TAPS)));

  // ks_data is the LFSR register itself, so the output is registered
  assign ks_data = lfsr;

  chaos_seed_collector #(
    .W (LFSR_W),
    .B (B)
  ) u_collector (
    .clk         (clk),
    .reset       (reset),
    .accept      (sample_accept),
    .clear       (collect_abort),
    .sample_bits (chaos_in[B-1:0]),
    .seed_done   (seed_done),
    .seed        (seed)
  );

  // Controller FSM, LFSR, word/reseed counters and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_W'(1);
      word_cnt     <= '0;
      reseed_count <= '0;
      chaos_ready  <= 1'b0;
      ks_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= COLLECT;
            chaos_ready <= 1'b1;
          end
        end

        COLLECT: begin
          if (!enable) begin
            state       <= IDLE;
            chaos_ready <= 1'b0;
          end else if (seed_done) begin
            // An all-zero seed would lock the LFSR at zero forever
            lfsr         <= (seed == '0) ? LFSR_W'(1) : seed;
            reseed_count <= reseed_count + 8'd1;
            word_cnt     <= '0;
            chaos_ready  <= 1'b0;
            ks_valid     <= 1'b1;
            state        <= RUN;
          end
        end

        RUN: begin
          if (ks_hs) begin
            lfsr     <= lfsr_step;
            word_cnt <= word_cnt + WCW'(1);
            // The period boundary takes priority over a simultaneous enable drop
            if (last_word) begin
              state       <= COLLECT;
              ks_valid    <= 1'b0;
              chaos_ready <= 1'b1;
            end else if (!enable) begin
              state    <= IDLE;
              ks_valid <= 1'b0;
            end
          end
        end

        default: begin
          state       <= IDLE;
          chaos_ready <= 1'b0;
          ks_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_lfsr_keystream.sv
module tb_chaos_lfsr_keystream;
  import chaos_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  q1_15_t      chaos_in;
  logic        chaos_valid;
  logic        chaos_ready;
  logic [15:0] ks_data;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  reseed_count;

  int n_chk;
  int n_fail;

  chaos_lfsr_keystream #(
    .LFSR_W          (16),
    .BITS_PER_SAMPLE (2),
    .RESEED_PERIOD   (4),
    .TAPS            (16'hB400)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .chaos_in     (chaos_in),
    .chaos_valid  (chaos_valid),
    .chaos_ready  (chaos_ready),
    .ks_data      (ks_data),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .reseed_count (reseed_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [0:7][15:0] samples;
    logic [0:3][15:0] words;
    logic [7:0]       reseeds;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Feed 8 samples, one per cycle; collector must be ready and no word valid in every slot
  task automatic feed(input string name, input logic [0:7][15:0] s);
    for (int i = 0; i < 8; i++) begin
      chk({name, " chaos_ready in collect"}, 16'(chaos_ready), 16'd1);
      chk({name, " ks_valid low in collect"}, 16'(ks_valid), 16'd0);
      chaos_in = s[i];
      @(negedge clk);
    end
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    chaos_in    = '0;
    chaos_valid = 1'b1;
    ks_ready    = 1'b0;

    vecs[0] = '{"seed_step",
                {16'h0001, 16'hFFFE, 16'h8003, 16'h7FFC, 16'h1235, 16'hCAFE, 16'h4567, 16'h89AC},
                {16'h6C6C, 16'h3636, 16'h1B1B, 16'hB98D}, 8'd1};
    vecs[1] = '{"zero_seed",
                {16'hFFFC, 16'h8000, 16'h7FF4, 16'h0004, 16'h1238, 16'hABCC, 16'h0000, 16'hFFF0},
                {16'h0001, 16'hB400, 16'h5A00, 16'h2D00}, 8'd2};
    vecs[2] = '{"all_ones",
                {16'h7FFF, 16'h8003, 16'h0003, 16'hFFFF, 16'h1237, 16'hABCB, 16'h000F, 16'hC0C3},
                {16'hFFFF, 16'hCBFF, 16'hD1FF, 16'hDCFF}, 8'd3};
    vecs[3] = '{"ends_one",
                {16'h0002, 16'hFFFC, 16'h0004, 16'h8000, 16'h0010, 16'h7FF8, 16'h1234, 16'hF001},
                {16'h8001, 16'hF400, 16'h7A00, 16'h3D00}, 8'd4};

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("reset ks_valid", 16'(ks_valid), 16'd0);
    chk("reset chaos_ready", 16'(chaos_ready), 16'd0);
    chk("reset ks_data", ks_data, 16'h0001);
    chk("reset reseed_count", 16'(reseed_count), 16'd0);

    reset    = 1'b0;
    enable   = 1'b1;
    ks_ready = 1'b1;
    @(negedge clk);

    // Table: each vector seeds, streams 4 words, then the period boundary forces a reseed
    for (int v = 0; v < 4; v++) begin
      feed(vecs[v].name, vecs[v].samples);
      for (int j = 0; j < 4; j++) begin
        chk({vecs[v].name, " ks_valid"}, 16'(ks_valid), 16'd1);
        chk({vecs[v].name, " ks_data"}, ks_data, vecs[v].words[j]);
        @(negedge clk);
      end
      chk({vecs[v].name, " reseed gap ks_valid"}, 16'(ks_valid), 16'd0);
      chk({vecs[v].name, " reseed gap chaos_ready"}, 16'(chaos_ready), 16'd1);
      chk({vecs[v].name, " reseed_count"}, 16'(reseed_count), 16'(vecs[v].reseeds));
    end

    // Backpressure: stall 5 cycles after the first word, nothing skipped
    feed("bp", vecs[0].samples);
    chk("bp word0", ks_data, 16'h6C6C);
    @(negedge clk);
    ks_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 16'(ks_valid), 16'd1);
      chk("bp hold data", ks_data, 16'h3636);
      @(negedge clk);
    end
    ks_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      chk("bp resume valid", 16'(ks_valid), 16'd1);
      chk("bp resume data", ks_data, vecs[0].words[j]);
      @(negedge clk);
    end
    chk("bp reseed chaos_ready", 16'(chaos_ready), 16'd1);
    chk("bp reseed_count", 16'(reseed_count), 16'd5);

    // Enable dropped on the last word of the period: reseed wins, then COLLECT aborts
    feed("prio", vecs[2].samples);
    for (int j = 0; j < 3; j++) begin
      chk("prio data", ks_data, vecs[2].words[j]);
      @(negedge clk);
    end
    chk("prio last data", ks_data, 16'hDCFF);
    enable = 1'b0;
    @(negedge clk);
    chk("prio goes collect", 16'(chaos_ready), 16'd1);
    chk("prio ks_valid", 16'(ks_valid), 16'd0);
    chk("prio reseed_count", 16'(reseed_count), 16'd6);
    @(negedge clk);
    chk("prio collect abort", 16'(chaos_ready), 16'd0);

    // Abort after 3 samples; re-enable must take 8 fresh samples
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chaos_in = 16'h0003;
      @(negedge clk);
    end
    enable = 1'b0;
    @(negedge clk);
    chk("abort idle ready", 16'(chaos_ready), 16'd0);
    @(negedge clk);
    chk("abort idle valid", 16'(ks_valid), 16'd0);
    enable = 1'b1;
    @(negedge clk);
    feed("refill", vecs[3].samples);
    chk("refill valid", 16'(ks_valid), 16'd1);
    chk("refill seed", ks_data, 16'h8001);
    chk("refill reseed_count", 16'(reseed_count), 16'd7);
    // Handshake mid-period with enable low goes to IDLE
    enable = 1'b0;
    @(negedge clk);
    chk("run->idle valid", 16'(ks_valid), 16'd0);
    chk("run->idle ready", 16'(chaos_ready), 16'd0);
    chk("run->idle stepped", ks_data, 16'hF400);

    // Reset mid-RUN
    enable = 1'b1;
    @(negedge clk);
    feed("midrun", vecs[1].samples);
    chk("midrun word0", ks_data, 16'h0001);
    @(negedge clk);
    chk("midrun word1", ks_data, 16'hB400);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun reset valid", 16'(ks_valid), 16'd0);
    chk("midrun reset ready", 16'(chaos_ready), 16'd0);
    chk("midrun reset data", ks_data, 16'h0001);
    chk("midrun reset count", 16'(reseed_count), 16'd0);

    // Reset mid-COLLECT
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midcollect ready", 16'(chaos_ready), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midcollect reset ready", 16'(chaos_ready), 16'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
